// File: rtl/ed25519_pkg.sv
// Shared types and sizing for the ED25519 fixed-base scalar multiplier
// command sequencing.
package ed25519_pkg;

  localparam int NDIGITS = 64;
  localparam int NPOS    = 32;
  localparam int DIGIT_W = 8;
  localparam int NDBL    = 4;

  // Datapath command opcode
  typedef enum logic {
    CMD_ADD = 1'b0,
    CMD_DBL = 1'b1
  } cmd_op_e;

  // Sequencer state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ODD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_EVEN = 2'd3
  } state_e;

endpackage

// File: rtl/scalar_digit_sched_digit_sign_mag.sv
// Signed radix-16 digit to sign/magnitude split. Pure combinational.
// abs_v is the low 4 bits of |d|, so -8 gives 8 and out-of-range digits wrap.
module digit_sign_mag
  import ed25519_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [3:0]         abs_v,
  output logic               neg,
  output logic               in_range
);

  logic [DIGIT_W-1:0] mag;

  assign neg      = d[DIGIT_W-1];
  assign mag      = neg ? DIGIT_W'(-d) : d;
  assign abs_v    = mag[3:0];
  // -128 negates to 0x80, which is correctly reported as out of range
  assign in_range = (mag <= DIGIT_W'(8));

endmodule

// File: rtl/scalar_digit_sched.sv
// Command sequencer: captures 64 signed digits, then issues 32 odd-digit ADDs,
// NDBL DBLs and 32 even-digit ADDs over a valid/ready handshake.
// Optional feature macro: SCALAR_DIGIT_SCHED_RANGE_CHECK_EN (sticky range_err
// flag for digits outside [-8, 8]); when undefined range_err is tied low.
module scalar_digit_sched
  import ed25519_pkg::*;
#(
  parameter int NDIGITS = 64,
  parameter int NDBL    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*NDIGITS-1:0]   e_in,
  output logic                   busy,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_op,
  output logic [4:0]             cmd_pos,
  output logic [3:0]             cmd_abs,
  output logic                   cmd_neg,
  output logic                   cmd_last,
  output logic                   done,
  output logic                   range_err
);

  localparam logic [4:0] KLAST   = 5'(NDIGITS/2 - 1);
  localparam logic [4:0] DBLLAST = 5'(NDBL - 1);

  state_e                          st_q;
  logic [4:0]                      k_q;
  cmd_op_e                         op_q;
  logic [NDIGITS-1:0][DIGIT_W-1:0] dig_q;   // dig_q[j] = e_in[8j+7:8j]
  logic                            hs;
  logic                            add_act;
  logic [5:0]                      sel_i;
  logic [DIGIT_W-1:0]              cur_digit;
  logic [3:0]                      cur_abs;
  logic                            cur_neg;
  logic                            cur_in_range_unused;

  assign hs      = cmd_valid & cmd_ready;
  assign add_act = cmd_valid & (op_q == CMD_ADD);

  // digit i lives at e_in[511-8i -: 8], i.e. dig_q[NDIGITS-1-i]
  assign sel_i     = {k_q, st_q == ST_ODD};
  assign cur_digit = dig_q[6'(NDIGITS-1) - sel_i];

  digit_sign_mag u_cmd_dsm (
    .d        (cur_digit),
    .abs_v    (cur_abs),
    .neg      (cur_neg),
    .in_range (cur_in_range_unused)
  );

  assign cmd_op  = op_q;
  assign cmd_pos = add_act ? k_q     : 5'd0;
  assign cmd_abs = add_act ? cur_abs : 4'd0;
  assign cmd_neg = add_act & cur_neg;

  // Sequencer FSM: state, index and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      k_q       <= '0;
      op_q      <= CMD_ADD;
      dig_q     <= '0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            dig_q     <= e_in;
            k_q       <= '0;
            op_q      <= CMD_ADD;
            st_q      <= ST_ODD;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_last  <= 1'b0;
          end
        end
        ST_ODD: begin
          if (hs) begin
            if (k_q == KLAST) begin
              k_q  <= '0;
              op_q <= CMD_DBL;
              st_q <= ST_DBL;
            end else begin
              k_q <= k_q + 5'd1;
            end
          end
        end
        ST_DBL: begin
          if (hs) begin
            if (k_q == DBLLAST) begin
              k_q  <= '0;
              op_q <= CMD_ADD;
              st_q <= ST_EVEN;
            end else begin
              k_q <= k_q + 5'd1;
            end
          end
        end
        ST_EVEN: begin
          if (hs) begin
            if (k_q == KLAST) begin
              k_q       <= '0;
              st_q      <= ST_IDLE;
              busy      <= 1'b0;
              cmd_valid <= 1'b0;
              cmd_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              k_q      <= k_q + 5'd1;
              cmd_last <= (k_q == KLAST - 5'd1);
            end
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCALAR_DIGIT_SCHED_RANGE_CHECK_EN
  logic [NDIGITS-1:0]      lane_ok;
  logic [NDIGITS-1:0][3:0] lane_abs_unused;
  logic [NDIGITS-1:0]      lane_neg_unused;
  logic                    rerr_q;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_chk
    digit_sign_mag u_chk (
      .d        (e_in[8*g +: 8]),
      .abs_v    (lane_abs_unused[g]),
      .neg      (lane_neg_unused[g]),
      .in_range (lane_ok[g])
    );
  end

  // Sticky flag, reloaded from the incoming digits on every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rerr_q <= 1'b0;
    else if (st_q == ST_IDLE && start) rerr_q <= ~&lane_ok;
  end

  assign range_err = rerr_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
